axil_reg_slave: RTL and testbench
=================================

Name: axil_reg_slave

Overview:
- AXI4-Lite responder, the slave end of the Module Validation Platform register interface that the AXI VIP master exercises.
- Holds NUM_REGS 32-bit read/write registers at word addresses 0x0, 0x4, 0x8, …
- Exposes register contents and a per-register write strobe to downstream SAT-solver logic.
- Independent write and read channels; one outstanding transaction per channel.

Parameters:
- NUM_REGS, 4, number of 32-bit registers (power of 2, 2..16).
- ADDR_W, 4, AXI address width; must satisfy 2^ADDR_W >= 4*NUM_REGS.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write-data handshake.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read-address handshake.
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data.
- regs_o  out  32*NUM_REGS  register contents; reg k occupies [32k+31:32k].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse, bit k high in the cycle after reg k is committed.

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. Synchronous, active-high reset S_AXI_ARESET.
- Reset values: all registers 0. AWREADY, WREADY, ARREADY 0 during reset. BVALID, RVALID 0. BRESP, RRESP, RDATA 0. wr_pulse_o 0. Holding flags cleared.
- Reset mid-transaction: in-flight AW/W/AR captures are discarded and no register is modified. VALIDs drop the cycle after reset asserts.

Write path:
- Two independent holding registers, aw_held and w_held, each with a valid flag.
- AWREADY = !aw_held && !BVALID && !reset.
- WREADY = !w_held && !BVALID && !reset.
- AW and W may arrive in either order or in the same cycle.
- Commit happens at the first edge where aw_held && w_held:
  - idx = addr[ADDR_W-1:2]; low two address bits are ignored.
  - Byte b of reg idx is updated only if WSTRB[b]=1.
  - BVALID is set, both held flags are cleared, and wr_pulse_o[idx] is high for the next cycle.
- Latency: AW and W handshaking together at edge N → commit at edge N+1 → BVALID visible from N+1.
- BVALID stays high until BREADY is sampled high. No new AW/W is accepted while BVALID=1.
- WSTRB=0 is still a completed write: BRESP=OKAY, register unchanged, wr_pulse_o still pulses.

Read path:
- ARREADY = !RVALID && !reset.
- AR handshake at edge N → RDATA/RRESP/RVALID registered at edge N (valid in cycle N+1).
- RDATA is held stable until RREADY is sampled high.

Boundary and simultaneous events:
- Read and write commit hitting the same register on the same edge: the read returns the pre-write value.
- Both channels run concurrently with no arbitration between them.
- Out-of-range index (idx >= NUM_REGS, only possible when 2^ADDR_W > 4*NUM_REGS): handled per the optional feature.

Optional Feature:
- Macro: AXIL_REG_SLAVE_DECERR_EN.
- Defined:
  - Out-of-range write: no register is modified, no wr_pulse_o, BRESP=SLVERR (2'b10).
  - Out-of-range read: RDATA=0, RRESP=SLVERR.
- Undefined: idx wraps modulo NUM_REGS, and BRESP/RRESP are always OKAY.

Decomposition:
- Package axil_pkg:
  - typedef axil_resp_t enum {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}.
  - localparam AXIL_DATA_W=32 and AXIL_STRB_W=4.
  - Function apply_wstrb(old, new, strb) returning the merged word.
- No sub-module: the write FSM (IDLE/HOLD/RESP via held flags) and the read FSM (IDLE/RESP) are small enough to stay inline.

Test Plan:
- Writes 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, BREADY=1, then sequential reads → each BRESP=OKAY; reads return 1,2,3,4; regs_o = {4,3,2,1}; wr_pulse_o bits 0..3 pulse once each.
- Write 0xFFFFFFFF to 0x4, then 0x000000AB with WSTRB=4'b0001 → read 0x4 returns 0xFFFFFFAB.
- W presented 3 cycles before AW; BREADY held low 5 cycles → WREADY low after W capture; AWREADY/WREADY low while BVALID=1; BVALID high 6 cycles; a second write is accepted only after the B handshake.
- Read 0x8 with RREADY low 4 cycles while a write of 0x55 to 0x8 commits → RDATA stays at the old value until RREADY; a later read returns 0x55.
- ADDR_W=5, write to 0x10: with AXIL_REG_SLAVE_DECERR_EN → BRESP=SLVERR, reg0 unchanged; without it → BRESP=OKAY, reg0 updated.
- Assert S_AXI_ARESET one cycle after an AW-only handshake → no commit; all outputs 0 the next cycle; all regs read back 0 after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register slave: response codes, bus widths
// and the byte-strobe merge used when committing a write.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = 4;

  function automatic logic [AXIL_DATA_W-1:0] apply_wstrb(
    input logic [AXIL_DATA_W-1:0] old_word,
    input logic [AXIL_DATA_W-1:0] new_word,
    input logic [AXIL_STRB_W-1:0] strb
  );
    logic [AXIL_DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < AXIL_STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave with NUM_REGS 32-bit registers and per-register write pulses.
// Define AXIL_REG_SLAVE_DECERR_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 4
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESET,
  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [AXIL_DATA_W-1:0]       S_AXI_WDATA,
  input  logic [AXIL_STRB_W-1:0]       S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [AXIL_DATA_W-1:0]       S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]       regs_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                   aw_held_reg;
  logic [ADDR_W-1:0]      aw_addr_reg;
  logic                   w_held_reg;
  logic [AXIL_DATA_W-1:0] w_data_reg;
  logic [AXIL_STRB_W-1:0] w_strb_reg;
  logic                   bvalid_reg;
  axil_resp_t             bresp_reg;
  logic                   rvalid_reg;
  axil_resp_t             rresp_reg;
  logic [AXIL_DATA_W-1:0] rdata_reg;
  logic [AXIL_DATA_W-1:0] regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]    wr_pulse_reg;
  logic [NUM_REGS-1:0]    reg_hit;

  logic             commit;
  logic             aw_oor;
  logic             ar_oor;
  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic             unused_bits;

  assign S_AXI_AWREADY = !aw_held_reg && !bvalid_reg && !S_AXI_ARESET;
  assign S_AXI_WREADY  = !w_held_reg && !bvalid_reg && !S_AXI_ARESET;
  assign S_AXI_ARREADY = !rvalid_reg && !S_AXI_ARESET;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign wr_pulse_o    = wr_pulse_reg;

  // Low index bits select the register; without the error feature upper bits simply wrap.
  assign commit = aw_held_reg && w_held_reg;
  assign aw_idx = aw_addr_reg[IDX_W+1:2];
  assign ar_idx = S_AXI_ARADDR[IDX_W+1:2];

`ifdef AXIL_REG_SLAVE_DECERR_EN
  assign aw_oor = 32'(aw_addr_reg[ADDR_W-1:2]) >= 32'(NUM_REGS);
  assign ar_oor = 32'(S_AXI_ARADDR[ADDR_W-1:2]) >= 32'(NUM_REGS);
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_addr_reg, S_AXI_ARADDR};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign reg_hit[gi]            = commit && !aw_oor && (aw_idx == IDX_W'(gi));
      assign regs_o[32*gi +: 32]    = regs_reg[gi];
    end
  endgenerate

  // Write channel: AW and W are captured independently; the commit edge raises BVALID.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_held_reg  <= 1'b0;
      aw_addr_reg  <= '0;
      w_held_reg   <= 1'b0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= OKAY;
      wr_pulse_reg <= '0;
    end else begin
      wr_pulse_reg <= reg_hit;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_held_reg <= 1'b1;
        aw_addr_reg <= S_AXI_AWADDR;
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_held_reg <= 1'b1;
        w_data_reg <= S_AXI_WDATA;
        w_strb_reg <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= aw_oor ? SLVERR : OKAY;
      end else if (bvalid_reg && S_AXI_BREADY) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) regs_reg[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (reg_hit[k]) regs_reg[k] <= apply_wstrb(regs_reg[k], w_data_reg, w_strb_reg);
      end
    end
  end

  // Read channel samples the array before any same-edge commit lands.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rvalid_reg <= 1'b0;
      rresp_reg  <= OKAY;
      rdata_reg  <= '0;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid_reg <= 1'b1;
      rresp_reg  <= ar_oor ? SLVERR : OKAY;
      rdata_reg  <= ar_oor ? '0 : regs_reg[ar_idx];
    end else if (rvalid_reg && S_AXI_RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed scoreboard bench for axil_reg_slave (NUM_REGS=4, ADDR_W=5 so 0x10 is out of range).
module tb_axil_reg_slave;

  localparam int NR = 4;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          S_AXI_ARESET;
  logic [AW-1:0] S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic [32*NR-1:0] regs_o;
  logic [NR-1:0]    wr_pulse_o;

  axil_reg_slave #(.NUM_REGS(NR), .ADDR_W(AW)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (S_AXI_ARESET),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWPROT (S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARPROT (S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .regs_o       (regs_o),
    .wr_pulse_o   (wr_pulse_o)
  );

  typedef struct {logic [1:0] resp; logic [NR-1:0] pulse;} b_exp_t;
  typedef struct {logic [31:0] data; logic [1:0] resp;} r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] model [NR];
  int          exp_pulses [NR];
  int          pulse_cnt [NR];
  int          vectors = 0;
  int          miscompares = 0;

  always @(negedge clk) begin
    for (int k = 0; k < NR; k++) if (wr_pulse_o[k] === 1'b1) pulse_cnt[k]++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: event did not occur within its cycle budget", tag);
  endtask

  task automatic push_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    b_exp_t e;
    int idx;
    idx = int'(addr[AW-1:2]);
`ifdef AXIL_REG_SLAVE_DECERR_EN
    if (idx >= NR) begin
      e.resp = 2'b10;
      e.pulse = '0;
      bq.push_back(e);
      return;
    end
`endif
    idx = idx % NR;
    e.resp = 2'b00;
    e.pulse = '0;
    e.pulse[idx] = 1'b1;
    exp_pulses[idx]++;
    for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    bq.push_back(e);
  endtask

  task automatic push_read(input logic [AW-1:0] addr);
    r_exp_t e;
    int idx;
    idx = int'(addr[AW-1:2]);
`ifdef AXIL_REG_SLAVE_DECERR_EN
    if (idx >= NR) begin
      e.data = '0;
      e.resp = 2'b10;
      rq.push_back(e);
      return;
    end
`endif
    e.data = model[idx % NR];
    e.resp = 2'b00;
    rq.push_back(e);
  endtask

  task automatic send_aw(input logic [AW-1:0] addr);
    bit done = 0;
    S_AXI_AWADDR = addr;
    S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (S_AXI_AWREADY === 1'b1) done = 1;
      step();
    end
    S_AXI_AWVALID = 1'b0;
    if (!done) timeout("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    bit done = 0;
    S_AXI_WDATA = data;
    S_AXI_WSTRB = strb;
    S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (S_AXI_WREADY === 1'b1) done = 1;
      step();
    end
    S_AXI_WVALID = 1'b0;
    if (!done) timeout("w_handshake");
  endtask

  task automatic send_ar(input logic [AW-1:0] addr);
    bit done = 0;
    S_AXI_ARADDR = addr;
    S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (S_AXI_ARREADY === 1'b1) done = 1;
      step();
    end
    S_AXI_ARVALID = 1'b0;
    if (!done) timeout("ar_handshake");
  endtask

  task automatic wait_b(input int hold);
    bit seen = 0;
    b_exp_t e;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (S_AXI_BVALID === 1'b1) seen = 1;
      else step();
    end
    if (!seen) begin timeout("bvalid"); return; end
    if (bq.size() == 0) begin timeout("b_expected"); return; end
    e = bq.pop_front();
    check("bresp", S_AXI_BRESP, e.resp);
    check("wr_pulse", wr_pulse_o, e.pulse);
    for (int h = 0; h < hold; h++) begin
      step();
      check("bvalid_hold", S_AXI_BVALID, 1'b1);
      check("awready_blocked", S_AXI_AWREADY, 1'b0);
      check("wready_blocked", S_AXI_WREADY, 1'b0);
    end
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
    check("bvalid_drop", S_AXI_BVALID, 1'b0);
  endtask

  task automatic wait_r(input int hold);
    bit seen = 0;
    r_exp_t e;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (S_AXI_RVALID === 1'b1) seen = 1;
      else step();
    end
    if (!seen) begin timeout("rvalid"); return; end
    if (rq.size() == 0) begin timeout("r_expected"); return; end
    e = rq.pop_front();
    check("rdata", S_AXI_RDATA, e.data);
    check("rresp", S_AXI_RRESP, e.resp);
    for (int h = 0; h < hold; h++) begin
      step();
      check("rdata_stable", S_AXI_RDATA, e.data);
      check("rvalid_hold", S_AXI_RVALID, 1'b1);
    end
    S_AXI_RREADY = 1'b1;
    step();
    S_AXI_RREADY = 1'b0;
    check("rvalid_drop", S_AXI_RVALID, 1'b0);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold);
    push_write(addr, data, strb);
    fork
      send_aw(addr);
      send_w(data, strb);
    join
    wait_b(hold);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int hold);
    push_read(addr);
    send_ar(addr);
    wait_r(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] packed_model;
    S_AXI_ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    for (int k = 0; k < NR; k++) begin
      model[k] = '0; exp_pulses[k] = 0; pulse_cnt[k] = 0;
    end
    repeat (3) step();
    check("rst_awready", S_AXI_AWREADY, 1'b0);
    check("rst_wready", S_AXI_WREADY, 1'b0);
    check("rst_arready", S_AXI_ARREADY, 1'b0);
    check("rst_bvalid", S_AXI_BVALID, 1'b0);
    check("rst_rvalid", S_AXI_RVALID, 1'b0);
    check("rst_regs", regs_o, '0);
    check("rst_pulse", wr_pulse_o, '0);
    S_AXI_ARESET = 1'b0;
    step();
    check("idle_awready", S_AXI_AWREADY, 1'b1);

    // Basic writes and read-back of every register
    for (int i = 0; i < NR; i++) do_write(AW'(4 * i), 32'(i + 1), 4'hF, 0);
    for (int i = 0; i < NR; i++) do_read(AW'(4 * i), 0);
    check("regs_o_basic", regs_o, {32'd4, 32'd3, 32'd2, 32'd1});

    // Byte-strobe merge
    do_write(AW'(4), 32'hFFFF_FFFF, 4'hF, 0);
    do_write(AW'(4), 32'h0000_00AB, 4'b0001, 0);
    do_read(AW'(4), 0);
    check("strb_merge", regs_o[63:32], 32'hFFFF_FFAB);

    // W leads AW by 3 cycles, then BREADY held low for 5 cycles
    push_write(AW'(8), 32'h0000_00C3, 4'hF);
    fork
      send_w(32'h0000_00C3, 4'hF);
      begin
        for (int i = 0; i < 3; i++) begin
          step();
          check("wready_after_w", S_AXI_WREADY, 1'b0);
          check("no_bvalid_w_only", S_AXI_BVALID, 1'b0);
        end
        send_aw(AW'(8));
      end
    join
    wait_b(5);
    do_write(AW'(12), 32'h0000_0044, 4'hF, 0);

    // Read held while a write to the same register commits
    push_read(AW'(8));
    send_ar(AW'(8));
    fork
      wait_r(4);
      do_write(AW'(8), 32'h0000_0055, 4'hF, 0);
    join
    do_read(AW'(8), 0);

    // Read handshake on the same edge as a write commit returns the old value
    push_read(AW'(4));
    push_write(AW'(4), 32'h1234_5678, 4'hF);
    fork
      send_aw(AW'(4));
      send_w(32'h1234_5678, 4'hF);
      begin
        step();
        send_ar(AW'(4));
      end
    join
    fork
      wait_b(0);
      wait_r(0);
    join
    do_read(AW'(4), 0);

    // Out-of-range address, then a zero-strobe write
    do_write(AW'(16), 32'hDEAD_BEEF, 4'hF, 0);
    do_read(AW'(0), 0);
    do_read(AW'(16), 0);
    do_write(AW'(12), 32'h0000_9999, 4'h0, 0);
    do_read(AW'(12), 0);

    // Reset after an AW-only handshake discards it
    send_aw(AW'(4));
    S_AXI_ARESET = 1'b1;
    step();
    check("mid_rst_awready", S_AXI_AWREADY, 1'b0);
    check("mid_rst_arready", S_AXI_ARREADY, 1'b0);
    check("mid_rst_bvalid", S_AXI_BVALID, 1'b0);
    check("mid_rst_bresp", S_AXI_BRESP, 2'b00);
    check("mid_rst_rdata", S_AXI_RDATA, 32'h0);
    check("mid_rst_regs", regs_o, '0);
    check("mid_rst_pulse", wr_pulse_o, '0);
    S_AXI_ARESET = 1'b0;
    for (int k = 0; k < NR; k++) model[k] = '0;
    step();
    send_w(32'h0000_0077, 4'hF);
    for (int i = 0; i < 4; i++) begin
      check("no_commit_after_rst", S_AXI_BVALID, 1'b0);
      step();
    end
    push_write(AW'(0), 32'h0000_0077, 4'hF);
    send_aw(AW'(0));
    wait_b(0);
    for (int i = 0; i < NR; i++) do_read(AW'(4 * i), 0);

    step();
    for (int k = 0; k < NR; k++) packed_model[32*k +: 32] = model[k];
    check("regs_o_final", regs_o, packed_model);
    for (int k = 0; k < NR; k++) check("pulse_count", 128'(pulse_cnt[k]), 128'(exp_pulses[k]));
    if (bq.size() != 0 || rq.size() != 0) timeout("scoreboard_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
